mem_port_arbiter: RTL

- Shares one single-port, fixed-latency memory between three requesters:
  - instruction fetch (IF stage),
  - data load/store (MEM stage),
  - an external loader/debug port (program load, memory inspection).
- Owns the memory port's sequencing: arbitration, one outstanding access, read-latency tracking and response routing.
- Sits between the IF/MEM stages and the memory macro. This is the step toward a unified-memory, multi-cycle core.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_if.sv | 65 ++++++
 rtl/mem_port_arbiter_prio_sel.sv | 21 ++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

  // Port sequencer states: arbitrate, drive the strobe, count latency, route data
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Owner of the current (or next) memory access
  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_IF   = 2'd1,
    SRC_D    = 2'd2,
    SRC_X    = 2'd3
  } src_t;

  // Wide all-ones byte enable; users slice off DW/8 bits
  localparam logic [127:0] BE_ALL = '1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory-side signal bundle for the arbiter
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
);

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic            d_req;
  logic            d_we;
  logic [DW/8-1:0] d_be;
  logic [AW-1:0]   d_addr;
  logic [DW-1:0]   d_wdata;
  logic            d_gnt;
  logic            d_rvalid;
  logic [DW-1:0]   d_rdata;

  logic          x_req;
  logic          x_we;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wdata;
  logic          x_gnt;
  logic          x_rvalid;
  logic [DW-1:0] x_rdata;

  logic            mem_en;
  logic            mem_we;
  logic [DW/8-1:0] mem_be;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  logic busy;

  // Arbiter side: serves the requesters, drives the memory macro
  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    input  x_req, x_we, x_addr, x_wdata,
    output x_gnt, x_rvalid, x_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  // Environment side: requesters plus the memory macro
  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    output x_req, x_we, x_addr, x_wdata,
    input  x_gnt, x_rvalid, x_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );

endinterface

// File: rtl/mem_port_arbiter_prio_sel.sv
// rtl/mem_port_arbiter_prio_sel.sv - fixed-priority winner select with IF starvation override
import mem_arb_pkg::*;

module arb_prio_sel (
  input  logic if_req,
  input  logic d_req,
  input  logic x_req,
  input  logic force_if,
  output src_t win
);

  // Loader beats data beats fetch, unless fetch has lost too many times in a row
  always_comb begin
    win = SRC_NONE;
    if (if_req && force_if) win = SRC_IF;
    else if (x_req)         win = SRC_X;
    else if (d_req)         win = SRC_D;
    else if (if_req)        win = SRC_IF;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory sequencer shared by fetch, data and loader
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic               clk,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned   SW = $clog2(STARVE_MAX + 1);
  localparam logic [DW/8-1:0] BE = BE_ALL[DW/8-1:0];

  arb_state_t      state;
  src_t            cur_src;
  src_t            win;
  logic [1:0]      lat_cnt;
  logic [SW-1:0]   starve_cnt;
  logic            force_if;

  logic            cap_we;
  logic [DW/8-1:0] cap_be;
  logic [AW-1:0]   cap_addr;
  logic [DW-1:0]   cap_wdata;

  logic            sel_we;
  logic [DW/8-1:0] sel_be;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;

  logic            if_rv_q, d_rv_q, x_rv_q;
  logic [DW-1:0]   if_rdata_q, d_rdata_q, x_rdata_q;

  assign force_if = (starve_cnt == SW'(STARVE_MAX));

  arb_prio_sel u_sel (
    .if_req   (bus.if_req),
    .d_req    (bus.d_req),
    .x_req    (bus.x_req),
    .force_if (force_if),
    .win      (win)
  );

  // Request fields of the would-be winner; reads always use full byte enables
  always_comb begin
    sel_we    = 1'b0;
    sel_be    = BE;
    sel_addr  = bus.if_addr;
    sel_wdata = '0;
    case (win)
      SRC_D: begin
        sel_we    = bus.d_we;
        sel_be    = bus.d_we ? bus.d_be : BE;
        sel_addr  = bus.d_addr;
        sel_wdata = bus.d_wdata;
      end
      SRC_X: begin
        sel_we    = bus.x_we;
        sel_addr  = bus.x_addr;
        sel_wdata = bus.x_wdata;
      end
      default: ;
    endcase
  end

  // Sequencer: capture winner in IDLE, strobe once, wait out read latency, route data
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      cur_src   <= SRC_NONE;
      lat_cnt   <= '0;
      cap_we    <= 1'b0;
      cap_be    <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win != SRC_NONE) begin
            cur_src   <= win;
            cap_we    <= sel_we;
            cap_be    <= sel_be;
            cap_addr  <= sel_addr & ~AW'(3);
            cap_wdata <= sel_wdata;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cap_we) begin
            state <= IDLE;
          end else if (MEM_LAT == 1) begin
            state <= RESP;
          end else begin
            lat_cnt <= 2'(MEM_LAT - 1);
            state   <= WAIT;
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 2'd1;
          if (lat_cnt == 2'd1) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Count IDLE arbitrations that fetch loses while it is asking
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (bus.if_req && (win != SRC_IF)) begin
        if (!force_if) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // Latch read data for the owner only; other requesters' rdata stays untouched
  always_ff @(posedge clk) begin
    if (!reset) begin
      if_rv_q    <= 1'b0;
      d_rv_q     <= 1'b0;
      x_rv_q     <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      x_rdata_q  <= '0;
    end else begin
      if_rv_q <= (state == RESP) && (cur_src == SRC_IF);
      d_rv_q  <= (state == RESP) && (cur_src == SRC_D);
      x_rv_q  <= (state == RESP) && (cur_src == SRC_X);
      if (state == RESP) begin
        case (cur_src)
          SRC_IF:  if_rdata_q <= bus.mem_rdata;
          SRC_D:   d_rdata_q  <= bus.mem_rdata;
          SRC_X:   x_rdata_q  <= bus.mem_rdata;
          default: ;
        endcase
      end
    end
  end

  assign bus.if_gnt    = (state == ISSUE) && (cur_src == SRC_IF);
  assign bus.d_gnt     = (state == ISSUE) && (cur_src == SRC_D);
  assign bus.x_gnt     = (state == ISSUE) && (cur_src == SRC_X);
  assign bus.if_rvalid = if_rv_q;
  assign bus.d_rvalid  = d_rv_q;
  assign bus.x_rvalid  = x_rv_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.x_rdata   = x_rdata_q;

  assign bus.mem_en    = (state == ISSUE);
  assign bus.mem_we    = (state == ISSUE) && cap_we;
  assign bus.mem_be    = cap_be;
  assign bus.mem_addr  = cap_addr;
  assign bus.mem_wdata = cap_wdata;
  assign bus.busy      = (state != IDLE);

endmodule
